// File: rtl/invaders_pkg.sv
// rtl/invaders_pkg.sv - shared types and ROM window constants for the invaders ROM loader
`timescale 1ns/1ps
package invaders_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_WRITE,
      ST_GAP,
      ST_HOLD
   } loader_state_t;

   // Program ROM occupies 0x0000-0x3FFF, colour PROM 0x4000-0x47FF
   localparam logic [15:0] PROG_BASE        = 16'h0000;
   localparam logic [15:0] CPROM_BASE       = 16'h4000;
   localparam logic [15:0] MAX_ADDR_DEFAULT = 16'h4800;

endpackage

// File: rtl/loader_down_counter.sv
// rtl/loader_down_counter.sv - loadable down counter with zero flag, shared by GAP and HOLD timing
`timescale 1ns/1ps
module loader_down_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/invaders_rom_loader.sv
// rtl/invaders_rom_loader.sv - filters the host ioctl byte stream onto the dn_* ROM download bus
`timescale 1ns/1ps
module invaders_rom_loader
   import invaders_pkg::*;
#(
   parameter int          GAP_CYCLES = 2,
   parameter int          RESET_HOLD = 16,
   parameter logic [15:0] MAX_ADDR   = MAX_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [15:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   output logic [15:0] dn_addr,
   output logic [7:0]  dn_data,
   output logic        dn_wr,
   output logic        cpu_reset,
   output logic        load_done,
   output logic        overrun,
   output logic [15:0] checksum
);

   // Counter is loaded with N-1 and the state exits on zero, so it lasts exactly N cycles
   localparam logic [7:0] GAP_LOAD  = 8'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
   localparam logic [7:0] HOLD_LOAD = 8'(RESET_HOLD - 1);

   loader_state_t state, state_n;

   logic       dl_q;
   logic       dl_rise;
   logic       cnt_load;
   logic       cnt_dec;
   logic       cnt_zero;
   logic [7:0] cnt_val;
   logic       start;
   logic       accept;
   logic       set_done;

   assign dl_rise = ioctl_download & ~dl_q;

   loader_down_counter #(.WIDTH(8)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_load = 1'b0;
      cnt_val  = GAP_LOAD;
      cnt_dec  = 1'b0;
      start    = 1'b0;
      accept   = 1'b0;
      set_done = 1'b0;
      case (state)
         ST_IDLE: begin
            if (dl_rise) begin
               state_n = ST_ACCEPT;
               start   = 1'b1;
            end
         end
         ST_ACCEPT: begin
            if (!ioctl_download) begin
               state_n  = ST_HOLD;
               cnt_load = 1'b1;
               cnt_val  = HOLD_LOAD;
            end else if (ioctl_wr && (ioctl_addr < MAX_ADDR)) begin
               state_n = ST_WRITE;
               accept  = 1'b1;
            end
         end
         ST_WRITE: begin
            if (GAP_CYCLES > 0) begin
               state_n  = ST_GAP;
               cnt_load = 1'b1;
               cnt_val  = GAP_LOAD;
            end else if (ioctl_download) begin
               state_n = ST_ACCEPT;
            end else begin
               state_n  = ST_HOLD;
               cnt_load = 1'b1;
               cnt_val  = HOLD_LOAD;
            end
         end
         ST_GAP: begin
            // A download that ended mid-write finishes its gap before the hold starts
            if (!cnt_zero) begin
               cnt_dec = 1'b1;
            end else if (ioctl_download) begin
               state_n = ST_ACCEPT;
            end else begin
               state_n  = ST_HOLD;
               cnt_load = 1'b1;
               cnt_val  = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (dl_rise) begin
               state_n = ST_ACCEPT;
               start   = 1'b1;
            end else if (cnt_zero) begin
               state_n  = ST_IDLE;
               set_done = 1'b1;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_q      <= 1'b0;
         dn_addr   <= 16'h0000;
         dn_data   <= 8'h00;
         checksum  <= 16'h0000;
         overrun   <= 1'b0;
         load_done <= 1'b0;
      end else begin
         dl_q <= ioctl_download;
         if (start) begin
            checksum  <= 16'h0000;
            overrun   <= 1'b0;
            load_done <= 1'b0;
         end
         if (accept) begin
            dn_addr  <= ioctl_addr;
            dn_data  <= ioctl_dout;
            checksum <= checksum + {8'h00, ioctl_dout};
         end
         if (ioctl_wr && ioctl_wait) begin
            overrun <= 1'b1;
         end
         if (set_done) begin
            load_done <= 1'b1;
         end
      end
   end

   assign dn_wr      = (state == ST_WRITE);
   assign ioctl_wait = (state == ST_WRITE) || (state == ST_GAP);
   assign cpu_reset  = !((state == ST_IDLE) && load_done);

endmodule

// File: tb/tb_invaders_rom_loader.sv
// tb/tb_invaders_rom_loader.sv - directed scoreboard bench for invaders_rom_loader
`timescale 1ns/1ps
module tb_invaders_rom_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [15:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic        ioctl_wait;
   logic [15:0] dn_addr;
   logic [7:0]  dn_data;
   logic        dn_wr;
   logic        cpu_reset;
   logic        load_done;
   logic        overrun;
   logic [15:0] checksum;

   invaders_rom_loader #(
      .GAP_CYCLES (2),
      .RESET_HOLD (16),
      .MAX_ADDR   (16'h4800)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_wait     (ioctl_wait),
      .dn_addr        (dn_addr),
      .dn_data        (dn_data),
      .dn_wr          (dn_wr),
      .cpu_reset      (cpu_reset),
      .load_done      (load_done),
      .overrun        (overrun),
      .checksum       (checksum)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_exp_t;

   wr_exp_t exp_q[$];
   wr_exp_t mon_e;
   int      n_checks = 0;
   int      n_fail   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Every dn_wr pulse must match the oldest expected write, at the expected cycle
   always @(negedge clk) begin
      if (dn_wr === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_dn_wr", 32'(dn_wr), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("dn_addr", 32'(dn_addr), 32'(mon_e.addr));
            chk("dn_data", 32'(dn_data), 32'(mon_e.data));
            chk("dn_wr_cycle", 32'(cyc), 32'(mon_e.cyc));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (ioctl_wait === 1'b1 && k < 50) begin
         k++;
         step();
      end
      chk("ready_timeout", 32'(ioctl_wait), 32'd0);
   endtask

   task automatic strobe(input logic [15:0] a, input logic [7:0] d, input bit expect_wr);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      if (expect_wr) exp_q.push_back('{addr: a, data: d, cyc: cyc + 1});
      step();
      ioctl_wr = 1'b0;
   endtask

   task automatic send_ok(input logic [15:0] a, input logic [7:0] d);
      int k = 0;
      wait_ready();
      strobe(a, d, 1'b1);
      while (ioctl_wait === 1'b1 && k < 50) begin
         k++;
         step();
      end
      chk("wait_len", 32'(k), 32'd3);
   endtask

   task automatic send_drop(input logic [15:0] a, input logic [7:0] d);
      wait_ready();
      strobe(a, d, 1'b0);
      chk("drop_wait", 32'(ioctl_wait), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      rst            = 1'b1;
      ioctl_download = 1'b0;
      ioctl_wr       = 1'b0;
      ioctl_addr     = 16'h0000;
      ioctl_dout     = 8'h00;
      repeat (3) step();
      rst = 1'b0;
      repeat (20) step();
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_dn_wr", 32'(dn_wr), 32'd0);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_checksum", 32'(checksum), 32'd0);
      chk("rst_wait", 32'(ioctl_wait), 32'd0);

      ioctl_download = 1'b1;
      step();
      send_ok(16'h0000, 8'hA5);
      send_ok(16'h1FFF, 8'h3C);
      send_ok(16'h4000, 8'h81);
      chk("checksum_3", 32'(checksum), 32'h0162);

      send_drop(16'h4800, 8'hFF);
      send_drop(16'h5000, 8'hFF);
      chk("checksum_drop", 32'(checksum), 32'h0162);
      chk("overrun_clear", 32'(overrun), 32'd0);

      // Strobe during the gap of an accepted byte
      wait_ready();
      strobe(16'h0010, 8'h12, 1'b1);
      step();
      strobe(16'h0020, 8'h77, 1'b0);
      chk("overrun_set", 32'(overrun), 32'd1);
      wait_ready();
      chk("checksum_overrun", 32'(checksum), 32'h0174);
      send_ok(16'h47FF, 8'h5A);
      chk("checksum_edge", 32'(checksum), 32'h01CE);

      // Drop the download during the gap
      wait_ready();
      strobe(16'h0001, 8'h01, 1'b1);
      step();
      ioctl_download = 1'b0;
      wait_ready();
      k = 0;
      while (cpu_reset === 1'b1 && k < 100) begin
         k++;
         step();
      end
      chk("hold_len", 32'(k), 32'd16);
      chk("done_load_done", 32'(load_done), 32'd1);
      chk("done_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("done_checksum", 32'(checksum), 32'h01CF);

      strobe(16'h0030, 8'h99, 1'b0);
      step();
      chk("idle_wr_checksum", 32'(checksum), 32'h01CF);

      // Restart clears the sticky status
      ioctl_download = 1'b1;
      step();
      chk("restart_checksum", 32'(checksum), 32'd0);
      chk("restart_load_done", 32'(load_done), 32'd0);
      chk("restart_overrun", 32'(overrun), 32'd0);
      chk("restart_cpu_reset", 32'(cpu_reset), 32'd1);

      // Async reset in the WRITE cycle
      wait_ready();
      strobe(16'h0100, 8'hC3, 1'b0);
      chk("pre_rst_dn_wr", 32'(dn_wr), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_dn_wr", 32'(dn_wr), 32'd0);
      chk("async_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("async_load_done", 32'(load_done), 32'd0);
      chk("async_wait", 32'(ioctl_wait), 32'd0);
      chk("async_checksum", 32'(checksum), 32'd0);
      ioctl_download = 1'b0;
      step();
      step();
      rst = 1'b0;
      repeat (5) step();
      chk("post_rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
